// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: redirect FSM states, branch-type and
// branch-mux select encodings, and the branch-taken helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RS  = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  localparam logic BT_BEQ = 1'b0;
  localparam logic BT_BNE = 1'b1;

  localparam logic BMUX_RS  = 1'b0;
  localparam logic BMUX_ALU = 1'b1;

  function automatic logic branch_taken(input logic branch, input logic btype,
                                        input logic zero);
    return branch & (zero ^ btype);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow sequencer: resolves beq/bne/jr, registers the
// redirect PC, issues one-cycle flushes and stalls on an unready jr source.
module branch_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STALL_MAX = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Branch_EX,
  input  logic             BranchType_EX,
  input  logic             Zero_EX,
  input  logic             JumpReg_EX,
  input  logic             RsReady_EX,
  input  logic [WIDTH-1:0] BranchTarget_EX,
  input  logic [WIDTH-1:0] ReadData1_EX,
  output logic             BranchMux_sel,
  output logic             Redirect_valid,
  output logic [WIDTH-1:0] Redirect_PC,
  output logic             Stall,
  output logic             Flush_IFID,
  output logic             Flush_IDEX,
  output logic [CNT_W-1:0] TakenCount,
  output logic             Timeout_err
);

  localparam int unsigned SC_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_e           state_q, state_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d, stall_inc;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             sel_q, sel_d;
  logic             tmo_q, tmo_d;
  logic             enter_redirect;

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    pc_d           = pc_q;
    sel_d          = sel_q;
    tmo_d          = tmo_q;
    enter_redirect = 1'b0;
    Stall          = 1'b0;
    stall_inc      = stall_cnt_q + SC_W'(1);

    case (state_q)
      S_IDLE: begin
        // jr takes priority over a simultaneous conditional branch
        if (JumpReg_EX) begin
          if (RsReady_EX) begin
            state_d        = S_REDIRECT;
            pc_d           = ReadData1_EX & ALIGN_MASK;
            sel_d          = BMUX_RS;
            enter_redirect = 1'b1;
          end else begin
            state_d     = S_WAIT_RS;
            stall_cnt_d = '0;
            Stall       = 1'b1;
          end
        end else if (branch_taken(Branch_EX, BranchType_EX, Zero_EX)) begin
          state_d        = S_REDIRECT;
          pc_d           = BranchTarget_EX & ALIGN_MASK;
          sel_d          = BMUX_ALU;
          enter_redirect = 1'b1;
        end
      end
      S_WAIT_RS: begin
        Stall = 1'b1;
        if (RsReady_EX) begin
          state_d        = S_REDIRECT;
          pc_d           = ReadData1_EX & ALIGN_MASK;
          sel_d          = BMUX_RS;
          enter_redirect = 1'b1;
        end else begin
          stall_cnt_d = stall_inc;
          if (stall_inc == SC_W'(STALL_MAX)) begin
            state_d = S_IDLE;
            tmo_d   = 1'b1;
          end
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      pc_q        <= '0;
      sel_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      pc_q        <= pc_d;
      sel_q       <= sel_d;
      tmo_q       <= tmo_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .en    (enter_redirect),
    .count (TakenCount)
  );

  assign Redirect_valid = (state_q == S_REDIRECT);
  assign Flush_IFID     = Redirect_valid;
  assign Flush_IDEX     = Redirect_valid;
  assign Redirect_PC    = pc_q;
  assign BranchMux_sel  = sel_q;
  assign Timeout_err    = tmo_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: cycle-by-cycle vector table plus
// sequences for jr timeout, reset during WAIT_RS and counter saturation.
module tb_branch_redirect_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Branch_EX, BranchType_EX, Zero_EX, JumpReg_EX, RsReady_EX;
  logic [31:0] BranchTarget_EX, ReadData1_EX;

  logic        sel, valid, stall, fl_ifid, fl_idex, tmo;
  logic [31:0] pc;
  logic [15:0] cnt;

  logic        s_sel, s_valid, s_stall, s_fl_ifid, s_fl_idex, s_tmo;
  logic [31:0] s_pc;
  logic [1:0]  s_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 Clk = ~Clk;

  branch_redirect_ctrl #(.WIDTH(32), .STALL_MAX(3), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Branch_EX(Branch_EX), .BranchType_EX(BranchType_EX),
    .Zero_EX(Zero_EX), .JumpReg_EX(JumpReg_EX), .RsReady_EX(RsReady_EX),
    .BranchTarget_EX(BranchTarget_EX), .ReadData1_EX(ReadData1_EX),
    .BranchMux_sel(sel), .Redirect_valid(valid), .Redirect_PC(pc), .Stall(stall),
    .Flush_IFID(fl_ifid), .Flush_IDEX(fl_idex), .TakenCount(cnt), .Timeout_err(tmo)
  );

  branch_redirect_ctrl #(.WIDTH(32), .STALL_MAX(3), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Branch_EX(Branch_EX), .BranchType_EX(BranchType_EX),
    .Zero_EX(Zero_EX), .JumpReg_EX(JumpReg_EX), .RsReady_EX(RsReady_EX),
    .BranchTarget_EX(BranchTarget_EX), .ReadData1_EX(ReadData1_EX),
    .BranchMux_sel(s_sel), .Redirect_valid(s_valid), .Redirect_PC(s_pc), .Stall(s_stall),
    .Flush_IFID(s_fl_ifid), .Flush_IDEX(s_fl_idex), .TakenCount(s_cnt), .Timeout_err(s_tmo)
  );

  typedef struct {
    logic        br, bt, z, jr, rdy;
    logic [31:0] tgt, rd1;
    logic        e_valid, e_sel;
    logic [31:0] e_pc;
    logic        e_stall;
    logic [15:0] e_cnt;
    logic        e_tmo;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic br, input logic bt, input logic z,
                              input logic jr, input logic rdy,
                              input logic [31:0] tgt, input logic [31:0] rd1,
                              input logic e_valid, input logic e_sel,
                              input logic [31:0] e_pc, input logic e_stall,
                              input logic [15:0] e_cnt, input logic e_tmo);
    vec_t v;
    v.br = br; v.bt = bt; v.z = z; v.jr = jr; v.rdy = rdy; v.tgt = tgt; v.rd1 = rd1;
    v.e_valid = e_valid; v.e_sel = e_sel; v.e_pc = e_pc; v.e_stall = e_stall;
    v.e_cnt = e_cnt; v.e_tmo = e_tmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic rst, input logic br, input logic bt, input logic z,
                       input logic jr, input logic rdy,
                       input logic [31:0] tgt, input logic [31:0] rd1);
    @(negedge Clk);
    Reset = rst; Branch_EX = br; BranchType_EX = bt; Zero_EX = z;
    JumpReg_EX = jr; RsReady_EX = rdy; BranchTarget_EX = tgt; ReadData1_EX = rd1;
    #1;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic e_sel,
                           input logic [31:0] e_pc, input logic e_stall,
                           input logic [15:0] e_cnt, input logic e_tmo);
    logic [1:0] e_scnt;
    e_scnt = (e_cnt > 16'd3) ? 2'd3 : e_cnt[1:0];
    chk({tag, " valid"}, {31'b0, valid}, {31'b0, e_valid});
    chk({tag, " flush_ifid"}, {31'b0, fl_ifid}, {31'b0, e_valid});
    chk({tag, " flush_idex"}, {31'b0, fl_idex}, {31'b0, e_valid});
    chk({tag, " sel"}, {31'b0, sel}, {31'b0, e_sel});
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " stall"}, {31'b0, stall}, {31'b0, e_stall});
    chk({tag, " cnt"}, {16'b0, cnt}, {16'b0, e_cnt});
    chk({tag, " tmo"}, {31'b0, tmo}, {31'b0, e_tmo});
    chk({tag, " sat_cnt"}, {30'b0, s_cnt}, {30'b0, e_scnt});
    chk({tag, " sat_valid"}, {31'b0, s_valid}, {31'b0, e_valid});
    chk({tag, " sat_stall"}, {31'b0, s_stall}, {31'b0, e_stall});
  endtask

  initial begin
    //                br    bt    z     jr    rdy   tgt           rd1           valid sel   pc            stall cnt    tmo
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'd0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h40,       1'b0, 16'd1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 16'd1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80,       32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 16'd1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 16'd1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h84,       32'h0,        1'b0, 1'b1, 32'h40,       1'b0, 16'd1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h84,       1'b0, 16'd2, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200,      32'h0,        1'b0, 1'b1, 32'h84,       1'b0, 16'd2, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h84,       1'b0, 16'd2, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h1003,     1'b0, 1'b1, 32'h84,       1'b1, 16'd2, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h1003,     1'b0, 1'b1, 32'h84,       1'b1, 16'd2, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h1000,     1'b0, 16'd3, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h1000,     1'b0, 16'd3, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300,      32'h2002,     1'b0, 1'b0, 32'h1000,     1'b0, 16'd3, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500,      32'h0,        1'b1, 1'b0, 32'h2000,     1'b0, 16'd4, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h2000,     1'b0, 16'd4, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h2000,     1'b0, 16'd4, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hFFFFFFFC, 1'b0, 16'd5, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 16'd5, 1'b0);

    idle(1'b1);
    idle(1'b1);
    check_all("reset", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b0, vecs[i].br, vecs[i].bt, vecs[i].z, vecs[i].jr, vecs[i].rdy,
            vecs[i].tgt, vecs[i].rd1);
      check_all($sformatf("row%0d", i), vecs[i].e_valid, vecs[i].e_sel, vecs[i].e_pc,
                vecs[i].e_stall, vecs[i].e_cnt, vecs[i].e_tmo);
    end

    // jr source never ready: one IDLE stall cycle plus three WAIT_RS cycles
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h44);
      check_all($sformatf("tmo_wait%0d", i), 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 16'd5, 1'b0);
    end
    idle(1'b0);
    check_all("tmo_set", 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 16'd5, 1'b1);
    idle(1'b0);
    check_all("tmo_sticky", 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 16'd5, 1'b1);

    // reset arriving while parked in WAIT_RS
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h88);
    check_all("rst_idle_jr", 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 16'd5, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h88);
    check_all("rst_in_wait", 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1, 16'd5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h88);
    check_all("rst_after", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 1'b0);
    idle(1'b0);
    check_all("rst_aborted", 1'b0, 1'b0, 32'h0, 1'b0, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
